eespfal_lane_sequencer: RTL and testbench

EESPFAL_LANE_SEQUENCER -- requirements
Module: eespfal_lane_sequencer

---
 rtl/eespfal_seq_pkg.sv | 17 +
 rtl/eespfal_phase_timer.sv | 34 +++
 rtl/eespfal_lane_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_eespfal_lane_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/eespfal_seq_pkg.sv
// rtl/eespfal_seq_pkg.sv - shared state encoding and default sizes for the EESPFAL lane sequencer
// Contents: DEF_BIT_SIZE / DEF_CNT_W defaults and the sequencer state enumeration.
package eespfal_seq_pkg;

  localparam int unsigned DEF_BIT_SIZE = 4;
  localparam int unsigned DEF_CNT_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DIS     = 3'd1,
    ST_SETUP   = 3'd2,
    ST_EVAL    = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

endpackage

// File: rtl/eespfal_phase_timer.sv
// rtl/eespfal_phase_timer.sv - loadable phase down-counter with zero clamp and expire flag
// Ports:
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   i_load, i_len      : load the counter with max(i_len,1)
//   o_expire           : high during the last cycle of the loaded phase
module eespfal_phase_timer
  import eespfal_seq_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // A zero length is promoted to one so every phase lasts at least a cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (i_len == '0) ? CNT_W'(1) : i_len;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Count value 1 is reached exactly once per load, giving a one-cycle flag.
  assign o_expire = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/eespfal_lane_sequencer.sv
// rtl/eespfal_lane_sequencer.sv - phase sequencer driving BIT_SIZE EESPFAL switch lanes
// Ports:
//   wb_clk_i, wb_rst_i            : clock, asynchronous active-high reset
//   start_i, abort_i              : request / terminate an evaluation
//   lane_en_i, x_i, k_i           : per-lane enable, operand, key (latched at accept)
//   t_dis_i, t_eval_i, t_hold_i   : phase lengths in cycles (latched at accept)
//   clk_o, dis_o, dis_phase_o     : power-clock, discharge drive, discharge strobe
//   x_o, x_bar_o, k_o, k_bar_o    : dual-rail operand and key drive
//   s_i, s_bar_i                  : dual-rail switch outputs
//   busy_o, done_o                : not-idle flag, completion pulse
//   result_o, err_o               : captured result and rail-error flags
module eespfal_lane_sequencer
  import eespfal_seq_pkg::*;
#(
  parameter int unsigned BIT_SIZE = DEF_BIT_SIZE,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [BIT_SIZE-1:0] lane_en_i,
  input  logic [BIT_SIZE-1:0] x_i,
  input  logic [BIT_SIZE-1:0] k_i,
  input  logic [CNT_W-1:0]    t_dis_i,
  input  logic [CNT_W-1:0]    t_eval_i,
  input  logic [CNT_W-1:0]    t_hold_i,
  output logic [BIT_SIZE-1:0] clk_o,
  output logic [BIT_SIZE-1:0] dis_o,
  output logic                dis_phase_o,
  output logic [BIT_SIZE-1:0] x_o,
  output logic [BIT_SIZE-1:0] x_bar_o,
  output logic [BIT_SIZE-1:0] k_o,
  output logic [BIT_SIZE-1:0] k_bar_o,
  input  logic [BIT_SIZE-1:0] s_i,
  input  logic [BIT_SIZE-1:0] s_bar_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [BIT_SIZE-1:0] result_o,
  output logic [BIT_SIZE-1:0] err_o
);

  state_t r_state, w_next;

  logic [BIT_SIZE-1:0] r_en, r_x, r_k;
  logic [CNT_W-1:0]    r_t_eval, r_t_hold;
  logic [BIT_SIZE-1:0] r_clk, r_dis, r_x_d, r_xb_d, r_k_d, r_kb_d, r_result, r_err;
  logic                r_dphase, r_done;

  logic                w_accept, w_load, w_capture, w_expire, w_dphase_n;
  logic [CNT_W-1:0]    w_len;
  logic [BIT_SIZE-1:0] w_en_n, w_clk_n, w_dis_n, w_x_n, w_xb_n, w_k_n, w_kb_n;

  eespfal_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .i_load   (w_load),
    .i_len    (w_len),
    .o_expire (w_expire)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Abort is tested before expiry in every active state so it always wins.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_len     = r_t_eval;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: if (start_i) begin
        w_next = ST_DIS;
        w_load = 1'b1;
        w_len  = t_dis_i;
      end
      ST_DIS: begin
        if (abort_i)       w_next = ST_RECOVER;
        else if (w_expire) w_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (abort_i) w_next = ST_RECOVER;
        else begin
          w_next = ST_EVAL;
          w_load = 1'b1;
          w_len  = r_t_eval;
        end
      end
      ST_EVAL: begin
        if (abort_i) w_next = ST_RECOVER;
        else if (w_expire) begin
          w_next = ST_HOLD;
          w_load = 1'b1;
          w_len  = r_t_hold;
        end
      end
      ST_HOLD: begin
        if (abort_i) w_next = ST_RECOVER;
        else if (w_expire) begin
          w_next    = ST_RECOVER;
          w_capture = 1'b1;
        end
      end
      ST_RECOVER: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && start_i;
  assign w_en_n   = w_accept ? lane_en_i : r_en;

  // Drive values are decoded from the next state and registered alongside it,
  // so the macro pins see flop outputs only.
  always_comb begin
    w_clk_n    = '0;
    w_dis_n    = '0;
    w_dphase_n = 1'b0;
    w_x_n      = '0;
    w_xb_n     = '0;
    w_k_n      = '0;
    w_kb_n     = '0;
    case (w_next)
      ST_DIS: begin
        w_dis_n    = w_en_n;
        w_dphase_n = 1'b1;
      end
      ST_SETUP, ST_EVAL, ST_HOLD: begin
        w_x_n  = r_x & r_en;
        w_xb_n = ~r_x & r_en;
        w_k_n  = r_k & r_en;
        w_kb_n = ~r_k & r_en;
        if (w_next != ST_SETUP) w_clk_n = r_en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_en     <= '0;
      r_x      <= '0;
      r_k      <= '0;
      r_t_eval <= '0;
      r_t_hold <= '0;
      r_clk    <= '0;
      r_dis    <= '0;
      r_dphase <= 1'b0;
      r_x_d    <= '0;
      r_xb_d   <= '0;
      r_k_d    <= '0;
      r_kb_d   <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_err    <= '0;
    end else begin
      if (w_accept) begin
        r_en     <= lane_en_i;
        r_x      <= x_i;
        r_k      <= k_i;
        r_t_eval <= t_eval_i;
        r_t_hold <= t_hold_i;
      end
      r_clk    <= w_clk_n;
      r_dis    <= w_dis_n;
      r_dphase <= w_dphase_n;
      r_x_d    <= w_x_n;
      r_xb_d   <= w_xb_n;
      r_k_d    <= w_k_n;
      r_kb_d   <= w_kb_n;
      r_done   <= w_capture;
      if (w_capture) begin
        r_result <= s_i & r_en;
        // Both rails equal means the lane failed to resolve.
        r_err    <= r_en & ~(s_i ^ s_bar_i);
      end
    end
  end

  assign clk_o       = r_clk;
  assign dis_o       = r_dis;
  assign dis_phase_o = r_dphase;
  assign x_o         = r_x_d;
  assign x_bar_o     = r_xb_d;
  assign k_o         = r_k_d;
  assign k_bar_o     = r_kb_d;
  assign done_o      = r_done;
  assign result_o    = r_result;
  assign err_o       = r_err;
  assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_eespfal_lane_sequencer.sv
// tb/tb_eespfal_lane_sequencer.sv - directed scoreboard bench for eespfal_lane_sequencer
module tb_eespfal_lane_sequencer;

  localparam int P_OFF = 0, P_DIS = 1, P_SET = 2, P_EVAL = 3, P_HOLD = 4;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       start_i, abort_i;
  logic [3:0] lane_en_i, x_i, k_i, s_i, s_bar_i;
  logic [7:0] t_dis_i, t_eval_i, t_hold_i;
  logic [3:0] clk_o, dis_o, x_o, x_bar_o, k_o, k_bar_o, result_o, err_o;
  logic       dis_phase_o, busy_o, done_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb_q[$];
  logic [3:0] cur_en, cur_x, cur_k;

  always #5 wb_clk_i = ~wb_clk_i;

  eespfal_lane_sequencer dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .abort_i(abort_i),
    .lane_en_i(lane_en_i), .x_i(x_i), .k_i(k_i),
    .t_dis_i(t_dis_i), .t_eval_i(t_eval_i), .t_hold_i(t_hold_i),
    .clk_o(clk_o), .dis_o(dis_o), .dis_phase_o(dis_phase_o),
    .x_o(x_o), .x_bar_o(x_bar_o), .k_o(k_o), .k_bar_o(k_bar_o),
    .s_i(s_i), .s_bar_i(s_bar_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  function automatic logic [31:0] drive_vec();
    return {7'b0, clk_o, dis_o, x_o, x_bar_o, k_o, k_bar_o, dis_phase_o};
  endfunction

  function automatic logic [31:0] exp_drive(input int ph);
    logic [3:0] c, d, x, xb, k, kb;
    logic       act;
    act = (ph == P_SET) || (ph == P_EVAL) || (ph == P_HOLD);
    c   = (ph == P_EVAL || ph == P_HOLD) ? cur_en : 4'h0;
    d   = (ph == P_DIS) ? cur_en : 4'h0;
    x   = act ? (cur_x & cur_en) : 4'h0;
    xb  = act ? (~cur_x & cur_en) : 4'h0;
    k   = act ? (cur_k & cur_en) : 4'h0;
    kb  = act ? (~cur_k & cur_en) : 4'h0;
    return {7'b0, c, d, x, xb, k, kb, (ph == P_DIS)};
  endfunction

  task automatic check_cycle(input string tag, input int ph, input logic busy_e, input logic done_e);
    chk({tag, "_drive"}, drive_vec(), exp_drive(ph));
    chk({tag, "_busy"}, 32'(busy_o), 32'(busy_e));
    chk({tag, "_done"}, 32'(done_o), 32'(done_e));
  endtask

  task automatic start_eval(input logic [3:0] en, x, k, input logic [7:0] td, te, th,
                            input logic [3:0] s, sb, input bit push);
    lane_en_i = en; x_i = x; k_i = k;
    t_dis_i = td; t_eval_i = te; t_hold_i = th;
    s_i = s; s_bar_i = sb;
    cur_en = en; cur_x = x; cur_k = k;
    if (push) sb_q.push_back({s & en, en & ~(s ^ sb)});
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    // scramble request inputs: the DUT must work from its latched copies
    lane_en_i = 4'($urandom); x_i = 4'($urandom); k_i = 4'($urandom);
    t_dis_i = 8'($urandom); t_eval_i = 8'($urandom); t_hold_i = 8'($urandom);
  endtask

  task automatic walk(input string tag, input int nd, input int ne, input int nh);
    for (int i = 0; i < nd; i++) begin check_cycle({tag, "_dis"}, P_DIS, 1'b1, 1'b0); tick(); end
    check_cycle({tag, "_setup"}, P_SET, 1'b1, 1'b0); tick();
    for (int i = 0; i < ne; i++) begin check_cycle({tag, "_eval"}, P_EVAL, 1'b1, 1'b0); tick(); end
    for (int i = 0; i < nh; i++) begin check_cycle({tag, "_hold"}, P_HOLD, 1'b1, 1'b0); tick(); end
  endtask

  task automatic compare_pop(input string tag);
    logic [7:0] e;
    chk({tag, "_sb_depth_nonzero"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_result"}, 32'(result_o), 32'(e[7:4]));
      chk({tag, "_err"}, 32'(err_o), 32'(e[3:0]));
    end
  endtask

  task automatic finish_eval(input string tag);
    check_cycle({tag, "_recover"}, P_OFF, 1'b1, 1'b1);
    compare_pop(tag);
    tick();
    check_cycle({tag, "_idle"}, P_OFF, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input string tag, input int exp_cycles, input int budget);
    int cycles;
    cycles = 0;
    while (done_o !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
    chk({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
    if (done_o === 1'b1) compare_pop(tag);
  endtask

  initial begin
    wb_rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    lane_en_i = '0; x_i = '0; k_i = '0; s_i = '0; s_bar_i = '0;
    t_dis_i = '0; t_eval_i = '0; t_hold_i = '0;
    cur_en = '0; cur_x = '0; cur_k = '0;
    #1;
    check_cycle("reset", P_OFF, 1'b0, 1'b0);
    chk("reset_result", 32'(result_o), 32'h0);
    chk("reset_err", 32'(err_o), 32'h0);
    tick();
    wb_rst_i = 1'b0;

    // t_dis=2, t_eval=3, t_hold=1; all lanes, clean dual-rail outputs
    start_eval(4'hF, 4'b1010, 4'b0110, 8'd2, 8'd3, 8'd1, 4'b1100, 4'b0011, 1'b1);
    walk("s1", 2, 3, 1);
    finish_eval("s1");

    // lanes 1 and 3 disabled; drive checks mask them via cur_en
    start_eval(4'b0101, 4'b1111, 4'b0000, 8'd1, 8'd1, 8'd2, 4'b1111, 4'b1010, 1'b1);
    walk("s2", 1, 1, 2);
    finish_eval("s2");
    chk("s2_disabled_lanes", 32'(result_o & 4'b1010), 32'h0);

    // all phase lengths zero behave as one; lane 2 has both rails high
    start_eval(4'hF, 4'b0011, 4'b1001, 8'd0, 8'd0, 8'd0, 4'b0101, 4'b0100, 1'b1);
    wait_done("s3", 4, 20);
    tick();

    // abort in EVAL cycle 2; start_i while busy must be ignored
    start_eval(4'hF, 4'b1100, 4'b0101, 8'd1, 8'd4, 8'd1, 4'b1010, 4'b0101, 1'b0);
    start_i = 1'b1;
    check_cycle("s4_dis", P_DIS, 1'b1, 1'b0); tick();
    start_i = 1'b0;
    check_cycle("s4_setup", P_SET, 1'b1, 1'b0); tick();
    check_cycle("s4_eval1", P_EVAL, 1'b1, 1'b0); tick();
    check_cycle("s4_eval2", P_EVAL, 1'b1, 1'b0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_cycle("s4_recover", P_OFF, 1'b1, 1'b0);
    chk("s4_result_kept", 32'(result_o), 32'h5);
    chk("s4_err_kept", 32'(err_o), 32'hE);
    tick();
    check_cycle("s4_idle", P_OFF, 1'b0, 1'b0);
    tick();
    chk("s4_no_done", 32'(done_o), 32'h0);

    // abort coinciding with HOLD expiry: abort wins, no capture
    start_eval(4'hF, 4'b0001, 4'b0010, 8'd1, 8'd1, 8'd1, 4'b1111, 4'b0000, 1'b0);
    walk("s5", 1, 1, 0);
    check_cycle("s5_hold", P_HOLD, 1'b1, 1'b0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_cycle("s5_recover", P_OFF, 1'b1, 1'b0);
    chk("s5_result_kept", 32'(result_o), 32'h5);
    tick();

    // reset mid-HOLD clears everything without a clock edge
    start_eval(4'hF, 4'b0110, 4'b0011, 8'd1, 8'd1, 8'd3, 4'b0011, 4'b1100, 1'b0);
    walk("s6", 1, 1, 0);
    check_cycle("s6_hold", P_HOLD, 1'b1, 1'b0);
    #2 wb_rst_i = 1'b1;
    #1;
    cur_en = '0;
    check_cycle("s6_async_rst", P_OFF, 1'b0, 1'b0);
    chk("s6_rst_result", 32'(result_o), 32'h0);
    chk("s6_rst_err", 32'(err_o), 32'h0);
    tick();
    wb_rst_i = 1'b0;
    start_eval(4'b0011, 4'b0010, 4'b0001, 8'd1, 8'd2, 8'd1, 4'b0001, 4'b0011, 1'b1);
    walk("s6b", 1, 2, 1);
    finish_eval("s6b");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
